// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared defaults, config record and period clamp for the programmable divider
package fdiv_pkg;
    localparam int DEF_CNT_W  = 28;
    localparam int DEF_PERIOD = 50_000_000;
    localparam int DEF_HIGH   = 25_000_000;
    typedef struct packed {
        logic [DEF_CNT_W-1:0] period;
        logic [DEF_CNT_W-1:0] high;
    } cfg_t;
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'd2) ? 32'd2 : p;
    endfunction
endpackage

// File: rtl/fdiv_chan.sv
// fdiv_chan: one divider channel with active/pending config swapped only at period boundaries
module fdiv_chan
    import fdiv_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int DEFAULT_HIGH   = DEF_HIGH
) (
    input  logic             clk_50mHz,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_all,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pend
);
    logic [CNT_W-1:0] cnt, act_p, act_h, pend_p, pend_h;
    logic [CNT_W-1:0] new_p, new_h, app_p, cnt_nx;
    logic             running, wrap;
    // a write landing on an apply edge bypasses the pending registers
    always_comb begin
        new_p  = cfg_we ? cfg_period : pend_p;
        new_h  = cfg_we ? cfg_high : pend_h;
        app_p  = CNT_W'(clamp_period(32'(new_p)));
        cnt_nx = cnt + 1'b1;
        wrap   = cnt == act_p - 1'b1;
    end
    always_ff @(posedge clk_50mHz or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            running  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_pend <= 1'b0;
            act_p    <= CNT_W'(DEFAULT_PERIOD);
            act_h    <= CNT_W'(DEFAULT_HIGH);
            pend_p   <= CNT_W'(DEFAULT_PERIOD);
            pend_h   <= CNT_W'(DEFAULT_HIGH);
        end else if (!en) begin
            cnt      <= '0;
            running  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_pend <= 1'b0;
            act_p    <= app_p;
            act_h    <= new_h;
            pend_p   <= new_p;
            pend_h   <= new_h;
        end else if (!running) begin
            running <= 1'b1;
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= act_h != '0;
            if (cfg_we) begin
                pend_p   <= cfg_period;
                pend_h   <= cfg_high;
                cfg_pend <= 1'b1;
            end
        end else if (sync_all || wrap) begin
            cnt      <= '0;
            tick     <= 1'b1;
            clk_out  <= new_h != '0;
            cfg_pend <= 1'b0;
            act_p    <= app_p;
            act_h    <= new_h;
            pend_p   <= new_p;
            pend_h   <= new_h;
        end else begin
            cnt     <= cnt_nx;
            tick    <= 1'b0;
            clk_out <= cnt_nx < act_h;
            if (cfg_we) begin
                pend_p   <= cfg_period;
                pend_h   <= cfg_high;
                cfg_pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fdiv_prog_multi.sv
// fdiv_prog_multi: CH independent programmable clock/tick dividers sharing one config port
module fdiv_prog_multi
    import fdiv_pkg::*;
#(
    parameter int CH             = 4,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int DEFAULT_HIGH   = DEF_HIGH,
    localparam int CH_W          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_50mHz,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             sync_all,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    cfg_pend
);
    // channel numbers >= CH never match, so such writes are dropped
    for (genvar i = 0; i < CH; i++) begin : g_ch
        fdiv_chan #(
            .CNT_W(CNT_W),
            .DEFAULT_PERIOD(DEFAULT_PERIOD),
            .DEFAULT_HIGH(DEFAULT_HIGH)
        ) u_chan (
            .clk_50mHz(clk_50mHz),
            .rst(rst),
            .en(en[i]),
            .sync_all(sync_all),
            .cfg_we(cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_period(cfg_period),
            .cfg_high(cfg_high),
            .clk_out(clk_out[i]),
            .tick(tick[i]),
            .cfg_pend(cfg_pend[i])
        );
    end
endmodule

// File: tb/tb_fdiv_prog_multi.sv
// tb_fdiv_prog_multi: directed tables, corner sequences and random traffic against a phase-based model
module tb_fdiv_prog_multi;
    localparam int CH = 4;
    localparam int W  = 28;
    logic          clk_50mHz = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] en = '0;
    logic          sync_all = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_high = '0;
    logic [CH-1:0] clk_out, tick, cfg_pend;
    int n_cmp = 0;
    int n_err = 0;

    fdiv_prog_multi #(.CH(CH), .CNT_W(W), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(5)) dut (
        .clk_50mHz(clk_50mHz), .rst(rst), .en(en), .sync_all(sync_all),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick), .cfg_pend(cfg_pend)
    );

    always #5 clk_50mHz = ~clk_50mHz;

    // model: each running channel sits at a phase inside its active period
    bit          run[CH];
    bit          pend[CH];
    int unsigned phase[CH], ap[CH], ah[CH], pp[CH], ph[CH];
    logic [CH-1:0] m_clk, m_tick, m_pend;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            run[c] = 0; pend[c] = 0; phase[c] = 0;
            ap[c] = 10; ah[c] = 5; pp[c] = 10; ph[c] = 5;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            bit wr;
            wr = cfg_we && (cfg_ch == 2'(c));
            if (wr) begin
                pp[c] = cfg_period;
                ph[c] = cfg_high;
            end
            if (!en[c]) begin
                run[c] = 0; phase[c] = 0; pend[c] = 0;
                ap[c] = (pp[c] < 2) ? 2 : pp[c]; ah[c] = ph[c];
            end else if (!run[c]) begin
                run[c] = 1; phase[c] = 0;
                if (wr) pend[c] = 1;
            end else if (sync_all || phase[c] + 1 == ap[c]) begin
                phase[c] = 0; pend[c] = 0;
                ap[c] = (pp[c] < 2) ? 2 : pp[c]; ah[c] = ph[c];
            end else begin
                phase[c]++;
                if (wr) pend[c] = 1;
            end
        end
        for (int c = 0; c < CH; c++) begin
            m_clk[c]  = run[c] && (phase[c] < ah[c]);
            m_tick[c] = run[c] && (phase[c] == 0);
            m_pend[c] = pend[c];
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] e, input logic s = 1'b0, input logic w = 1'b0,
                       input logic [1:0] c = 2'd0, input int p = 0, input int h = 0);
        en = e; sync_all = s; cfg_we = w; cfg_ch = c;
        cfg_period = W'(p); cfg_high = W'(h);
        model_step();
        @(posedge clk_50mHz);
        #1;
        chk("model clk_out", 32'(clk_out), 32'(m_clk));
        chk("model tick", 32'(tick), 32'(m_tick));
        chk("model cfg_pend", 32'(cfg_pend), 32'(m_pend));
        cfg_we = 1'b0; sync_all = 1'b0;
    endtask

    task automatic measure(input int c, output int len, output int hi);
        hi = int'(clk_out[c]);
        len = 0;
        do begin
            cyc(en);
            len++;
            if (!tick[c]) hi += int'(clk_out[c]);
        end while (!tick[c] && len < 64);
    endtask

    typedef struct {
        logic [3:0]  en_w;
        logic        we;
        logic [1:0]  ch;
        int          p, h;
        logic [3:0]  en_r;
        int          obs, n;
        logic [15:0] clk_bits, tick_bits;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int len, hi;
        model_reset();
        tbl[0] = '{4'b0000, 1'b0, 2'd0, 0, 0, 4'b0001, 0, 16, 16'hF83E, 16'h8020};
        tbl[1] = '{4'b0000, 1'b1, 2'd1, 4, 1, 4'b0010, 1, 12, 16'h0888, 16'h0888};
        tbl[2] = '{4'b0000, 1'b1, 2'd0, 0, 1, 4'b0001, 0, 8, 16'h00AA, 16'h00AA};
        tbl[3] = '{4'b0000, 1'b1, 2'd0, 5, 7, 4'b0001, 0, 10, 16'h03FF, 16'h0210};
        tbl[4] = '{4'b0000, 1'b1, 2'd0, 5, 0, 4'b0001, 0, 10, 16'h0000, 16'h0210};
        #12;
        chk("reset clk_out", 32'(clk_out), 0);
        chk("reset tick", 32'(tick), 0);
        chk("reset cfg_pend", 32'(cfg_pend), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].en_w, 1'b0, tbl[i].we, tbl[i].ch, tbl[i].p, tbl[i].h);
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].en_r);
                chk($sformatf("row%0d clk k%0d", i, k), 32'(clk_out[tbl[i].obs]), 32'(tbl[i].clk_bits[tbl[i].n-1-k]));
                chk($sformatf("row%0d tick k%0d", i, k), 32'(tick[tbl[i].obs]), 32'(tbl[i].tick_bits[tbl[i].n-1-k]));
            end
        end
        // reprogram mid-period, then on the wrap edge itself
        cyc(4'b0000, 1'b0, 1'b1, 2'd0, 10, 5);
        cyc(4'b0001); cyc(4'b0001); cyc(4'b0001);
        cyc(4'b0001, 1'b0, 1'b1, 2'd0, 6, 3);
        chk("pend set", 32'(cfg_pend[0]), 1);
        len = 3;
        do begin
            cyc(4'b0001);
            len++;
            if (!tick[0]) chk("pend hold", 32'(cfg_pend[0]), 1);
        end while (!tick[0] && len < 40);
        chk("old period len", len, 10);
        chk("pend cleared", 32'(cfg_pend[0]), 0);
        measure(0, len, hi);
        chk("new period len", len, 6);
        chk("new high len", hi, 3);
        for (int k = 0; k < 5; k++) cyc(4'b0001);
        cyc(4'b0001, 1'b0, 1'b1, 2'd0, 4, 2);
        chk("wrap write tick", 32'(tick[0]), 1);
        chk("wrap write pend", 32'(cfg_pend[0]), 0);
        measure(0, len, hi);
        chk("bypass period len", len, 4);
        chk("bypass high len", hi, 2);
        // sync_all aligns channels running at different phases
        cyc(4'b0000);
        cyc(4'b0001); cyc(4'b0001); cyc(4'b0001);
        cyc(4'b0101); cyc(4'b0101);
        cyc(4'b0101, 1'b1, 1'b1, 2'd0, 10, 5);
        chk("sync ticks", 32'(tick), 32'h5);
        chk("sync pend", 32'(cfg_pend), 0);
        for (int k = 0; k < 12; k++) begin
            cyc(4'b0101);
            chk("aligned clk", 32'(clk_out[0]), 32'(clk_out[2]));
            chk("ch3 idle", 32'({clk_out[3], tick[3]}), 0);
        end
        cyc(4'b0101, 1'b0, 1'b1, 2'(7), 3, 1);
        chk("ch7 write pend", 32'(cfg_pend), 0);
        // async reset mid-high
        len = 0;
        do begin cyc(4'b0101); len++; end while (!tick[0] && len < 20);
        cyc(4'b0101, 1'b0, 1'b1, 2'd2, 8, 4);
        chk("pre-rst pend", 32'(cfg_pend[2]), 1);
        chk("pre-rst high", 32'(clk_out[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async clk_out", 32'(clk_out), 0);
        chk("async tick", 32'(tick), 0);
        chk("async cfg_pend", 32'(cfg_pend), 0);
        model_reset();
        #1 rst = 1'b0;
        cyc(4'b0100);
        chk("en drop clk", 32'(clk_out[0]), 0);
        chk("restart tick", 32'(tick[2]), 1);
        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [3:0] e;
            for (int c = 0; c < CH; c++) e[c] = ($urandom_range(0, 7) != 0);
            cyc(e, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
